rat_ckpt: RTL and testbench
===========================

# rat_ckpt

Checkpointing register alias table for the out-of-order core's rename stage. Renames up to NSIZE instructions per cycle with intra-group bypass and tracks per-architectural-register readiness from CDB broadcasts. It also takes up to CKPT_COUNT branch snapshots of the full map, so a branch mispredict restores the map in one cycle without waiting for the ROB-head flush. It sits between decode/free-list and dispatch, alongside the ROB and RRF.

## Interface
- PHYS_BITS, 6, physical register index width
- ARCH_BITS, 5, architectural register index width (ARCH_COUNT = 2^ARCH_BITS)
- NSIZE, 2, rename lanes per cycle
- CDB_COUNT, 2, CDB broadcast ports
- CKPT_COUNT, 4, branch checkpoints (power of 2, ≥2); CKPT_BITS = $clog2(CKPT_COUNT)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ren_valid[NSIZE]  in  1  lane carries an instruction this cycle
- ren_we[NSIZE]  in  1  lane writes rd
- ren_rd[NSIZE]  in  ARCH_BITS  destination arch reg
- ren_pd[NSIZE]  in  PHYS_BITS  newly allocated phys reg
- ren_rs1/ren_rs2[NSIZE]  in  ARCH_BITS  sources
- ren_ps1/ren_ps2[NSIZE]  out  PHYS_BITS  source phys regs
- ren_ps1_valid/ren_ps2_valid[NSIZE]  out  1  source value already available
- ren_ckpt[NSIZE]  in  1  lane is a branch requesting a checkpoint
- ckpt_id  out  CKPT_BITS  id assigned to this cycle's checkpoint (tail)
- ckpt_full  out  1  no free checkpoint slot; frontend must not assert ren_ckpt
- global_cdb[CDB_COUNT]  in  cdb_t  uses .ready, .ar_dest, .pr_dest
- br_resolve  in  1  branch resolution event
- br_id  in  CKPT_BITS  checkpoint of resolved branch
- br_mispredict  in  1  resolution was a mispredict
- rob_flush  in  1  full architectural recovery
- RRF_in[ARCH_COUNT]  in  PHYS_BITS  retirement map
- rrf_we[NSIZE], rrf_rd[NSIZE], rrf_pd[NSIZE]  in  —  same-cycle commits, bypassed into flush restore

## Operation
- State: map[ARCH_COUNT], rdy[ARCH_COUNT]; snapshots smap/srdy[CKPT_COUNT]; slot live bits; tail pointer (CKPT_BITS).
- Lookup (combinational): psN = map[rsN], validN = rdy[rsN]. Override by the youngest earlier lane j<i with ren_valid&ren_we and ren_rd[j]==rsN[i] (pd, valid 0). Arch reg 0 always returns phys 0, valid 1.
- Update: for each valid lane with we and rd≠0, map[rd]<=pd, rdy[rd]<=0. On a same-rd collision, the highest lane wins.
- CDB: for each ready port with map[ar_dest]==pr_dest, set rdy. Apply the same match against every live snapshot, setting srdy. Rename writes in the same cycle override CDB sets for that arch reg.
- Checkpoint: at most one ren_ckpt lane per cycle (lane k). Slot tail captures the map/rdy after applying lanes 0..k and this cycle's CDB sets, excluding lanes >k. The slot becomes live and tail increments (mod CKPT_COUNT). ckpt_full = live[tail].
- Correct resolve: live[br_id]<=0. tail is unchanged.
- Mispredict: map/rdy <= snapshot br_id plus this cycle's CDB sets. Clear live for br_id through tail-1 (wrapping). tail<=br_id. Same-cycle rename/checkpoint inputs are ignored.
- rob_flush: map[i] <= rrf_pd of the highest committing lane with rrf_rd==i, else RRF_in[i]. All rdy<=1, all live<=0, tail<=0.
- Priority: rst > rob_flush > mispredict > (rename, checkpoint, CDB, correct resolve).
- Reset: map[i]=i, rdy all 1, live all 0, tail 0. Therefore ckpt_full=0 and ckpt_id=0.

## Timing
- Lookup outputs are same-cycle combinational. Map, rdy, and checkpoint effects are visible the next cycle.
- Restore and flush latency: 1 cycle. The first post-recovery rename reads the restored map.
- ckpt_full depends only on registered state, so there is no combinational path from ren_ckpt.
- Resolving and reallocating the same slot in one cycle is illegal when the slot is full; the freed slot is usable the next cycle.
- rst mid-operation discards all snapshots within 1 cycle.

## Test plan
- Reset, then read all rs lanes → ps=rs index and valid=1. Lane0 x5←p40, lane1 reads x5 in the same cycle → p40, valid 0. Next cycle x5 → p40, valid 0.
- CDB {ready, ar5, p40} → x5 valid. Stale CDB {ar5, p33} after remap → no change.
- Checkpoint on lane0 (x3←p20), lane1 x3←p21, mispredict id0 next cycle → x3 maps p20, tail=0, live=0.
- Allocate 4 checkpoints → ckpt_full=1. Correctly resolve id0 → ckpt_full=0 next cycle. Mispredict id1 with live {1,2,3} → all cleared, tail=1.
- Snapshot holds x7→p50 not ready, CDB p50 before mispredict → restored x7 is valid.
- rob_flush with RRF_in[4]=p9 and same-cycle commit rrf_rd=4, rrf_pd=p12 → x4=p12, all valid. Also verify flush and mispredict asserted together → flush wins.

Source files
------------

// File: rtl/rat_ckpt.sv
// Checkpointing register alias table: NSIZE-wide rename with intra-group bypass,
// CDB-driven readiness, and single-cycle branch restore from map snapshots.
package rat_ckpt_pkg;
  localparam int unsigned CDB_PHYS_BITS = 6;
  localparam int unsigned CDB_ARCH_BITS = 5;

  typedef struct packed {
    logic                     ready;
    logic [CDB_ARCH_BITS-1:0] ar_dest;
    logic [CDB_PHYS_BITS-1:0] pr_dest;
  } cdb_t;
endpackage

module rat_ckpt #(
  parameter int unsigned PHYS_BITS  = rat_ckpt_pkg::CDB_PHYS_BITS,
  parameter int unsigned ARCH_BITS  = rat_ckpt_pkg::CDB_ARCH_BITS,
  parameter int unsigned NSIZE      = 2,
  parameter int unsigned CDB_COUNT  = 2,
  parameter int unsigned CKPT_COUNT = 4,
  localparam int unsigned CKPT_BITS  = $clog2(CKPT_COUNT),
  localparam int unsigned ARCH_COUNT = 2 ** ARCH_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NSIZE-1:0]                      ren_valid,
  input  logic [NSIZE-1:0]                      ren_we,
  input  logic [NSIZE-1:0][ARCH_BITS-1:0]       ren_rd,
  input  logic [NSIZE-1:0][PHYS_BITS-1:0]       ren_pd,
  input  logic [NSIZE-1:0][ARCH_BITS-1:0]       ren_rs1,
  input  logic [NSIZE-1:0][ARCH_BITS-1:0]       ren_rs2,
  output logic [NSIZE-1:0][PHYS_BITS-1:0]       ren_ps1,
  output logic [NSIZE-1:0][PHYS_BITS-1:0]       ren_ps2,
  output logic [NSIZE-1:0]                      ren_ps1_valid,
  output logic [NSIZE-1:0]                      ren_ps2_valid,
  input  logic [NSIZE-1:0]                      ren_ckpt,
  output logic [CKPT_BITS-1:0]                  ckpt_id,
  output logic                                  ckpt_full,
  input  rat_ckpt_pkg::cdb_t [CDB_COUNT-1:0]    global_cdb,
  input  logic                                  br_resolve,
  input  logic [CKPT_BITS-1:0]                  br_id,
  input  logic                                  br_mispredict,
  input  logic                                  rob_flush,
  input  logic [ARCH_COUNT-1:0][PHYS_BITS-1:0]  RRF_in,
  input  logic [NSIZE-1:0]                      rrf_we,
  input  logic [NSIZE-1:0][ARCH_BITS-1:0]       rrf_rd,
  input  logic [NSIZE-1:0][PHYS_BITS-1:0]       rrf_pd
);

  logic [ARCH_COUNT-1:0][PHYS_BITS-1:0]                 map_q, map_d;
  logic [ARCH_COUNT-1:0]                                rdy_q, rdy_d;
  logic [CKPT_COUNT-1:0][ARCH_COUNT-1:0][PHYS_BITS-1:0] smap_q, smap_d;
  logic [CKPT_COUNT-1:0][ARCH_COUNT-1:0]                srdy_q, srdy_d;
  logic [CKPT_COUNT-1:0]                                live_q, live_d;
  logic [CKPT_BITS-1:0]                                 tail_q, tail_d;

  logic [ARCH_COUNT-1:0]                                cdb_set;
  logic [CKPT_COUNT-1:0][ARCH_COUNT-1:0]                scdb_set;
  logic [CKPT_BITS-1:0]                                 span;

  assign ckpt_id   = tail_q;
  assign ckpt_full = live_q[tail_q];
  assign span      = tail_q - br_id;

  // Source lookup: youngest earlier lane writing the same arch reg wins.
  always_comb begin
    for (int i = 0; i < NSIZE; i++) begin
      ren_ps1[i]       = map_q[ren_rs1[i]];
      ren_ps1_valid[i] = rdy_q[ren_rs1[i]];
      ren_ps2[i]       = map_q[ren_rs2[i]];
      ren_ps2_valid[i] = rdy_q[ren_rs2[i]];
      for (int j = 0; j < i; j++) begin
        if (ren_valid[j] && ren_we[j]) begin
          if (ren_rd[j] == ren_rs1[i]) begin
            ren_ps1[i]       = ren_pd[j];
            ren_ps1_valid[i] = 1'b0;
          end
          if (ren_rd[j] == ren_rs2[i]) begin
            ren_ps2[i]       = ren_pd[j];
            ren_ps2_valid[i] = 1'b0;
          end
        end
      end
      if (ren_rs1[i] == '0) begin
        ren_ps1[i]       = '0;
        ren_ps1_valid[i] = 1'b1;
      end
      if (ren_rs2[i] == '0) begin
        ren_ps2[i]       = '0;
        ren_ps2_valid[i] = 1'b1;
      end
    end
  end

  // Next state: flush, then mispredict restore, then the normal rename cycle.
  always_comb begin
    map_d    = map_q;
    rdy_d    = rdy_q;
    smap_d   = smap_q;
    srdy_d   = srdy_q;
    live_d   = live_q;
    tail_d   = tail_q;
    cdb_set  = '0;
    scdb_set = '0;

    for (int p = 0; p < CDB_COUNT; p++) begin
      if (global_cdb[p].ready) begin
        if (map_q[global_cdb[p].ar_dest] == global_cdb[p].pr_dest)
          cdb_set[global_cdb[p].ar_dest] = 1'b1;
        for (int s = 0; s < CKPT_COUNT; s++) begin
          if (live_q[s] && smap_q[s][global_cdb[p].ar_dest] == global_cdb[p].pr_dest)
            scdb_set[s][global_cdb[p].ar_dest] = 1'b1;
        end
      end
    end
    for (int s = 0; s < CKPT_COUNT; s++) srdy_d[s] = srdy_q[s] | scdb_set[s];

    if (rob_flush) begin
      for (int a = 0; a < ARCH_COUNT; a++) begin
        map_d[a] = RRF_in[a];
        for (int l = 0; l < NSIZE; l++) begin
          if (rrf_we[l] && rrf_rd[l] == ARCH_BITS'(a)) map_d[a] = rrf_pd[l];
        end
      end
      rdy_d  = '1;
      live_d = '0;
      tail_d = '0;
    end else if (br_resolve && br_mispredict) begin
      map_d = smap_q[br_id];
      rdy_d = srdy_q[br_id] | scdb_set[br_id];
      // span of zero with br_id live means the ring is full: kill every slot
      for (int s = 0; s < CKPT_COUNT; s++) begin
        if (span == '0 || CKPT_BITS'(CKPT_BITS'(s) - br_id) < span) live_d[s] = 1'b0;
      end
      tail_d = br_id;
    end else begin
      rdy_d = rdy_q | cdb_set;
      if (br_resolve) live_d[br_id] = 1'b0;
      for (int l = 0; l < NSIZE; l++) begin
        if (ren_valid[l]) begin
          if (ren_we[l] && ren_rd[l] != '0) begin
            map_d[ren_rd[l]] = ren_pd[l];
            rdy_d[ren_rd[l]] = 1'b0;
          end
          if (ren_ckpt[l]) begin
            smap_d[tail_q] = map_d;
            srdy_d[tail_q] = rdy_d;
            live_d[tail_q] = 1'b1;
            tail_d         = CKPT_BITS'(tail_q + 1'b1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < ARCH_COUNT; a++) map_q[a] <= PHYS_BITS'(a);
      rdy_q  <= '1;
      live_q <= '0;
      tail_q <= '0;
    end else begin
      map_q  <= map_d;
      rdy_q  <= rdy_d;
      live_q <= live_d;
      tail_q <= tail_d;
    end
  end

  // Snapshot storage is only meaningful while its live bit is set.
  always_ff @(posedge clk) begin
    smap_q <= smap_d;
    srdy_q <= srdy_d;
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Bench for rat_ckpt: directed scenarios then random traffic, all checked
// against an array-based reference model of the rename map and checkpoint ring.
module tb_rat_ckpt;
  localparam int unsigned PB = 6, AB = 5, NS = 2, NC = 2, CK = 4, CB = 2, AC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [NS-1:0] ren_valid, ren_we, ren_ckpt, ren_ps1_valid, ren_ps2_valid, rrf_we;
  logic [NS-1:0][AB-1:0] ren_rd, ren_rs1, ren_rs2, rrf_rd;
  logic [NS-1:0][PB-1:0] ren_pd, ren_ps1, ren_ps2, rrf_pd;
  logic [CB-1:0] ckpt_id, br_id;
  logic ckpt_full, br_resolve, br_mispredict, rob_flush;
  rat_ckpt_pkg::cdb_t [NC-1:0] global_cdb;
  logic [AC-1:0][PB-1:0] RRF_in;

  rat_ckpt dut (
    .clk(clk), .rst(rst), .ren_valid(ren_valid), .ren_we(ren_we), .ren_rd(ren_rd),
    .ren_pd(ren_pd), .ren_rs1(ren_rs1), .ren_rs2(ren_rs2), .ren_ps1(ren_ps1),
    .ren_ps2(ren_ps2), .ren_ps1_valid(ren_ps1_valid), .ren_ps2_valid(ren_ps2_valid),
    .ren_ckpt(ren_ckpt), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .global_cdb(global_cdb), .br_resolve(br_resolve), .br_id(br_id),
    .br_mispredict(br_mispredict), .rob_flush(rob_flush), .RRF_in(RRF_in),
    .rrf_we(rrf_we), .rrf_rd(rrf_rd), .rrf_pd(rrf_pd)
  );

  int checks = 0;
  int errors = 0;

  int unsigned m_map[AC];
  bit          m_rdy[AC];
  int unsigned s_map[CK][AC];
  bit          s_rdy[CK][AC];
  bit          m_live[CK];
  int          m_tail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int a = 0; a < AC; a++) begin
      m_map[a] = a;
      m_rdy[a] = 1'b1;
    end
    for (int s = 0; s < CK; s++) m_live[s] = 1'b0;
    m_tail = 0;
  endfunction

  function automatic void mdl_lookup(input int lane, input int rs, output int ps, output bit v);
    bit found = 1'b0;
    ps = m_map[rs];
    v  = m_rdy[rs];
    for (int j = lane - 1; j >= 0; j--) begin
      if (!found && ren_valid[j] && ren_we[j] && int'(ren_rd[j]) == rs) begin
        ps = ren_pd[j];
        v  = 1'b0;
        found = 1'b1;
      end
    end
    if (rs == 0) begin
      ps = 0;
      v  = 1'b1;
    end
  endfunction

  function automatic void mdl_update();
    bit hit[AC];
    bit shit[CK][AC];
    int idx;
    int b;
    bit found;
    if (rst) begin
      mdl_reset();
      return;
    end
    if (rob_flush) begin
      for (int a = 0; a < AC; a++) begin
        m_map[a] = RRF_in[a];
        found = 1'b0;
        for (int l = NS - 1; l >= 0; l--) begin
          if (!found && rrf_we[l] && int'(rrf_rd[l]) == a) begin
            m_map[a] = rrf_pd[l];
            found = 1'b1;
          end
        end
        m_rdy[a] = 1'b1;
      end
      for (int s = 0; s < CK; s++) m_live[s] = 1'b0;
      m_tail = 0;
      return;
    end
    for (int a = 0; a < AC; a++) begin
      hit[a] = 1'b0;
      for (int s = 0; s < CK; s++) shit[s][a] = 1'b0;
    end
    for (int p = 0; p < NC; p++) begin
      if (global_cdb[p].ready) begin
        if (m_map[global_cdb[p].ar_dest] == global_cdb[p].pr_dest) hit[global_cdb[p].ar_dest] = 1'b1;
        for (int s = 0; s < CK; s++)
          if (m_live[s] && s_map[s][global_cdb[p].ar_dest] == global_cdb[p].pr_dest)
            shit[s][global_cdb[p].ar_dest] = 1'b1;
      end
    end
    for (int s = 0; s < CK; s++)
      for (int a = 0; a < AC; a++) if (shit[s][a]) s_rdy[s][a] = 1'b1;
    if (br_resolve && br_mispredict) begin
      b = br_id;
      for (int a = 0; a < AC; a++) begin
        m_map[a] = s_map[b][a];
        m_rdy[a] = s_rdy[b][a];
      end
      idx = b;
      do begin
        m_live[idx] = 1'b0;
        idx = (idx + 1) % CK;
      end while (idx != m_tail);
      m_tail = b;
    end else begin
      for (int a = 0; a < AC; a++) if (hit[a]) m_rdy[a] = 1'b1;
      if (br_resolve) m_live[br_id] = 1'b0;
      for (int l = 0; l < NS; l++) begin
        if (ren_valid[l]) begin
          if (ren_we[l] && ren_rd[l] != 0) begin
            m_map[ren_rd[l]] = ren_pd[l];
            m_rdy[ren_rd[l]] = 1'b0;
          end
          if (ren_ckpt[l]) begin
            for (int a = 0; a < AC; a++) begin
              s_map[m_tail][a] = m_map[a];
              s_rdy[m_tail][a] = m_rdy[a];
            end
            m_live[m_tail] = 1'b1;
            m_tail = (m_tail + 1) % CK;
          end
        end
      end
    end
  endfunction

  task automatic check_outputs();
    int ps;
    bit v;
    for (int i = 0; i < NS; i++) begin
      mdl_lookup(i, int'(ren_rs1[i]), ps, v);
      chk($sformatf("ps1[%0d]", i), 32'(ren_ps1[i]), 32'(ps));
      chk($sformatf("ps1_valid[%0d]", i), 32'(ren_ps1_valid[i]), 32'(v));
      mdl_lookup(i, int'(ren_rs2[i]), ps, v);
      chk($sformatf("ps2[%0d]", i), 32'(ren_ps2[i]), 32'(ps));
      chk($sformatf("ps2_valid[%0d]", i), 32'(ren_ps2_valid[i]), 32'(v));
    end
    chk("ckpt_id", 32'(ckpt_id), 32'(m_tail));
    chk("ckpt_full", 32'(ckpt_full), 32'(m_live[m_tail]));
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    mdl_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 1'b0; ren_valid = '0; ren_we = '0; ren_ckpt = '0; ren_rd = '0; ren_pd = '0;
    ren_rs1 = '0; ren_rs2 = '0; global_cdb = '0; br_resolve = 1'b0; br_id = '0;
    br_mispredict = 1'b0; rob_flush = 1'b0; rrf_we = '0; rrf_rd = '0; rrf_pd = '0;
  endtask

  task automatic rand_inputs();
    int k;
    int live_list[$];
    clear_inputs();
    for (int l = 0; l < NS; l++) begin
      ren_valid[l] = ($urandom_range(0, 3) != 0);
      ren_we[l]    = ($urandom_range(0, 3) != 0);
      ren_rd[l]    = AB'($urandom_range(0, 7));
      ren_pd[l]    = PB'($urandom);
      ren_rs1[l]   = AB'($urandom_range(0, 7));
      ren_rs2[l]   = AB'($urandom);
      rrf_we[l]    = $urandom_range(0, 1);
      rrf_rd[l]    = AB'($urandom_range(0, 7));
      rrf_pd[l]    = PB'($urandom);
    end
    if ($urandom_range(0, 1) == 1) ren_rs1[1] = ren_rd[0];
    if (!m_live[m_tail] && $urandom_range(0, 2) == 0) begin
      k = $urandom_range(0, NS - 1);
      ren_valid[k] = 1'b1;
      ren_ckpt[k]  = 1'b1;
    end
    for (int s = 0; s < CK; s++) if (m_live[s]) live_list.push_back(s);
    for (int p = 0; p < NC; p++) begin
      global_cdb[p].ready   = $urandom_range(0, 1);
      global_cdb[p].ar_dest = AB'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: global_cdb[p].pr_dest = PB'(m_map[global_cdb[p].ar_dest]);
        1: global_cdb[p].pr_dest = (live_list.size() > 0) ?
             PB'(s_map[live_list[$urandom_range(0, live_list.size() - 1)]][global_cdb[p].ar_dest]) :
             PB'($urandom);
        default: global_cdb[p].pr_dest = PB'($urandom);
      endcase
    end
    if (live_list.size() > 0 && $urandom_range(0, 3) == 0) begin
      br_resolve    = 1'b1;
      br_id         = CB'(live_list[$urandom_range(0, live_list.size() - 1)]);
      br_mispredict = ($urandom_range(0, 2) == 0);
    end
    if ($urandom_range(0, 49) == 0) begin
      rob_flush = 1'b1;
      for (int a = 0; a < AC; a++) RRF_in[a] = PB'($urandom);
    end
    if ($urandom_range(0, 299) == 0) rst = 1'b1;
  endtask

  int id_save;

  initial begin
    clear_inputs();
    for (int a = 0; a < AC; a++) RRF_in[a] = PB'(a);
    mdl_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset map is identity and fully ready
    ren_rs1[0] = 5'd5; ren_rs1[1] = 5'd31; ren_rs2[0] = 5'd0; ren_rs2[1] = 5'd17;
    #1;
    chk("rst_ps1_l0", 32'(ren_ps1[0]), 5);
    chk("rst_ps1_l1", 32'(ren_ps1[1]), 31);
    chk("rst_ps2_l1", 32'(ren_ps2[1]), 17);
    chk("rst_valid", 32'({ren_ps1_valid, ren_ps2_valid}), 15);
    chk("rst_full", 32'(ckpt_full), 0);
    chk("rst_id", 32'(ckpt_id), 0);
    tick();

    // intra-group bypass then registered map
    clear_inputs();
    ren_valid = 2'b11; ren_we[0] = 1'b1; ren_rd[0] = 5'd5; ren_pd[0] = 6'd40; ren_rs1[1] = 5'd5;
    #1;
    chk("bypass_ps", 32'(ren_ps1[1]), 40);
    chk("bypass_valid", 32'(ren_ps1_valid[1]), 0);
    tick();
    clear_inputs();
    ren_rs1[0] = 5'd5;
    #1;
    chk("map_ps", 32'(ren_ps1[0]), 40);
    chk("map_valid", 32'(ren_ps1_valid[0]), 0);
    global_cdb[0] = '{ready: 1'b1, ar_dest: 5'd5, pr_dest: 6'd40};
    tick();
    clear_inputs();
    ren_rs1[0] = 5'd5;
    #1;
    chk("cdb_valid", 32'(ren_ps1_valid[0]), 1);
    ren_valid[0] = 1'b1; ren_we[0] = 1'b1; ren_rd[0] = 5'd5; ren_pd[0] = 6'd45;
    tick();
    clear_inputs();
    global_cdb[1] = '{ready: 1'b1, ar_dest: 5'd5, pr_dest: 6'd33};
    tick();
    clear_inputs();
    ren_rs1[0] = 5'd5;
    #1;
    chk("stale_cdb_ps", 32'(ren_ps1[0]), 45);
    chk("stale_cdb_valid", 32'(ren_ps1_valid[0]), 0);
    tick();

    // checkpoint on lane0, younger lane1 write, mispredict restores lane0 view
    clear_inputs();
    ren_valid = 2'b11; ren_we = 2'b11; ren_rd[0] = 5'd3; ren_pd[0] = 6'd20;
    ren_rd[1] = 5'd3; ren_pd[1] = 6'd21; ren_ckpt[0] = 1'b1;
    tick();
    clear_inputs();
    ren_rs1[0] = 5'd3;
    #1;
    chk("pre_mp_ps", 32'(ren_ps1[0]), 21);
    chk("pre_mp_id", 32'(ckpt_id), 1);
    br_resolve = 1'b1; br_mispredict = 1'b1; br_id = 2'd0;
    ren_valid[0] = 1'b1; ren_we[0] = 1'b1; ren_rd[0] = 5'd3; ren_pd[0] = 6'd7;
    tick();
    clear_inputs();
    ren_rs1[0] = 5'd3;
    #1;
    chk("mp_ps", 32'(ren_ps1[0]), 20);
    chk("mp_tail", 32'(ckpt_id), 0);
    chk("mp_live", 32'(ckpt_full), 0);
    tick();

    // fill the ring, free slot0, then wrap-clear 1..3
    for (int n = 0; n < CK; n++) begin
      clear_inputs();
      ren_valid[0] = 1'b1; ren_ckpt[0] = 1'b1;
      tick();
    end
    clear_inputs();
    #1;
    chk("full_set", 32'(ckpt_full), 1);
    br_resolve = 1'b1; br_id = 2'd0;
    tick();
    clear_inputs();
    #1;
    chk("full_freed", 32'(ckpt_full), 0);
    br_resolve = 1'b1; br_mispredict = 1'b1; br_id = 2'd1;
    tick();
    clear_inputs();
    #1;
    chk("wrap_tail", 32'(ckpt_id), 1);
    chk("wrap_full", 32'(ckpt_full), 0);
    ren_valid[0] = 1'b1; ren_ckpt[0] = 1'b1;
    tick();
    clear_inputs();
    #1;
    chk("wrap_slot2_dead", 32'(ckpt_full), 0);
    tick();

    // snapshot picks up a CDB broadcast while it waits
    clear_inputs();
    id_save = m_tail;
    ren_valid[0] = 1'b1; ren_we[0] = 1'b1; ren_rd[0] = 5'd7; ren_pd[0] = 6'd50; ren_ckpt[0] = 1'b1;
    tick();
    clear_inputs();
    ren_valid[0] = 1'b1; ren_we[0] = 1'b1; ren_rd[0] = 5'd7; ren_pd[0] = 6'd51;
    tick();
    clear_inputs();
    global_cdb[0] = '{ready: 1'b1, ar_dest: 5'd7, pr_dest: 6'd50};
    tick();
    clear_inputs();
    br_resolve = 1'b1; br_mispredict = 1'b1; br_id = CB'(id_save);
    tick();
    clear_inputs();
    ren_rs2[1] = 5'd7;
    #1;
    chk("snap_cdb_ps", 32'(ren_ps2[1]), 50);
    chk("snap_cdb_valid", 32'(ren_ps2_valid[1]), 1);
    tick();

    // flush with same-cycle commits beats a concurrent mispredict
    clear_inputs();
    id_save = m_tail;
    ren_valid[0] = 1'b1; ren_ckpt[0] = 1'b1;
    tick();
    clear_inputs();
    RRF_in[4] = 6'd9;
    RRF_in[6] = 6'd2;
    rob_flush = 1'b1; rrf_we = 2'b11;
    rrf_rd[0] = 5'd4; rrf_pd[0] = 6'd12; rrf_rd[1] = 5'd6; rrf_pd[1] = 6'd14;
    br_resolve = 1'b1; br_mispredict = 1'b1; br_id = CB'(id_save);
    tick();
    clear_inputs();
    ren_rs1[0] = 5'd4; ren_rs2[0] = 5'd6; ren_rs1[1] = 5'd7;
    #1;
    chk("flush_x4", 32'(ren_ps1[0]), 12);
    chk("flush_x6", 32'(ren_ps2[0]), 14);
    chk("flush_x7", 32'(ren_ps1[1]), 7);
    chk("flush_valid", 32'({ren_ps1_valid, ren_ps2_valid}), 15);
    chk("flush_tail", 32'(ckpt_id), 0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
